// File: rtl/a429_tx_ctrl.sv
// ARINC429 transmit sequencer.
// Snapshots the keypad digits and rate on a start edge, builds a 32-bit word with
// odd parity, shifts it out as bipolar return-to-zero on txa/txb, then holds the
// line null for the inter-word gap before pulsing done.
module a429_tx_ctrl #(
    parameter int unsigned BIT_DIV_HI = 500,
    parameter int unsigned BIT_DIV_LO = 4000,
    parameter int unsigned GAP_BITS   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        send_rate,
    input  logic [3:0]  dat0,
    input  logic [3:0]  dat1,
    input  logic [3:0]  dat2,
    input  logic [3:0]  dat3,
    input  logic [3:0]  dat4,
    input  logic [3:0]  dat5,
    output logic        busy,
    output logic        done,
    output logic        txa,
    output logic        txb,
    output logic [31:0] word_out,
    output logic [4:0]  bit_idx
);

    // Cycle counter is sized for the slower of the two rates.
    localparam int unsigned DivMax = (BIT_DIV_LO > BIT_DIV_HI) ? BIT_DIV_LO : BIT_DIV_HI;
    localparam int unsigned CntW   = $clog2(DivMax);
    localparam int unsigned GapW   = (GAP_BITS > 2) ? $clog2(GAP_BITS) : 1;

    localparam logic [CntW-1:0] HiLast  = CntW'(BIT_DIV_HI - 1);
    localparam logic [CntW-1:0] LoLast  = CntW'(BIT_DIV_LO - 1);
    localparam logic [CntW-1:0] HiHalf  = CntW'(BIT_DIV_HI / 2);
    localparam logic [CntW-1:0] LoHalf  = CntW'(BIT_DIV_LO / 2);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_BITS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

    state_e            state_q, state_d;
    logic              start_d_q;
    logic              rate_q;
    logic [31:0]       word_q;
    logic [4:0]        bit_idx_q;
    logic [CntW-1:0]   cyc_q;
    logic [GapW-1:0]   gap_q;

    logic              trigger;
    logic              bit_last;
    logic              gap_last;
    logic [CntW-1:0]   half;
    logic [4:0]        sel;
    logic              cur_bit;
    logic              drive;
    logic [30:0]       word_body;
    logic [31:0]       word_asm;

    // Decode timing, bit selection and the word to be latched at LOAD.
    always_comb begin
        trigger   = (state_q == StIdle) && start && !start_d_q;
        bit_last  = (cyc_q == (rate_q ? LoLast : HiLast));
        gap_last  = (gap_q == GapLast);
        half      = rate_q ? LoHalf : HiHalf;
        // Label goes out MSB first, everything above it LSB first.
        sel       = (bit_idx_q < 5'd8) ? (5'd7 - bit_idx_q) : bit_idx_q;
        cur_bit   = word_q[sel];
        word_body = {5'b0, dat5, dat4, dat3, dat2, 2'b0, dat1, dat0};
        word_asm  = {~(^word_body), word_body};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (trigger) state_d = StLoad;
            StLoad: state_d = StSend;
            StSend: if (bit_last && (bit_idx_q == 5'd31)) state_d = StGap;
            StGap:  if (bit_last && gap_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: edge detect, snapshot at LOAD, bit and gap counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Set high so a start held through reset is not seen as an edge.
            start_d_q <= 1'b1;
            rate_q    <= 1'b0;
            word_q    <= '0;
            bit_idx_q <= '0;
            cyc_q     <= '0;
            gap_q     <= '0;
        end else begin
            start_d_q <= start;
            unique case (state_q)
                StLoad: begin
                    rate_q    <= send_rate;
                    word_q    <= word_asm;
                    bit_idx_q <= '0;
                    cyc_q     <= '0;
                    gap_q     <= '0;
                end
                StSend: begin
                    if (bit_last) begin
                        cyc_q <= '0;
                        if (bit_idx_q != 5'd31) bit_idx_q <= bit_idx_q + 5'd1;
                    end else begin
                        cyc_q <= cyc_q + CntW'(1);
                    end
                end
                StGap: begin
                    if (bit_last) begin
                        cyc_q <= '0;
                        gap_q <= gap_q + GapW'(1);
                    end else begin
                        cyc_q <= cyc_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: RZ line drive during the first half of each bit, status flags.
    always_comb begin
        drive    = (state_q == StSend) && (cyc_q < half);
        txa      = drive & cur_bit;
        txb      = drive & ~cur_bit;
        busy     = (state_q != StIdle);
        done     = (state_q == StGap) && bit_last && gap_last;
        word_out = word_q;
        bit_idx  = bit_idx_q;
    end

endmodule

// File: tb/tb_a429_tx_ctrl.sv
// Directed bench for a429_tx_ctrl with short bit periods (HI=4, LO=8, GAP=4).
module tb_a429_tx_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        send_rate;
    logic [3:0]  dat0, dat1, dat2, dat3, dat4, dat5;
    logic        busy, done, txa, txb;
    logic [31:0] word_out;
    logic [4:0]  bit_idx;

    int checks = 0;
    int passes = 0;

    a429_tx_ctrl #(
        .BIT_DIV_HI(4),
        .BIT_DIV_LO(8),
        .GAP_BITS  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .send_rate(send_rate),
        .dat0     (dat0),
        .dat1     (dat1),
        .dat2     (dat2),
        .dat3     (dat3),
        .dat4     (dat4),
        .dat5     (dat5),
        .busy     (busy),
        .done     (done),
        .txa      (txa),
        .txb      (txb),
        .word_out (word_out),
        .bit_idx  (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit later; lines must never both be high.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        assert (!(txa === 1'b1 && txb === 1'b1)) passes++;
        else $error("FAIL txa_txb_excl: observed txa=%b txb=%b expected not both 1", txa, txb);
    endtask

    // Pulse start and follow one whole word, checking line shape cycle by cycle.
    task automatic run_word(input logic [31:0] w, input int p, input string tag,
                            input int edge_k, input int tog_k);
        int busy_cnt, done_cnt, done_k, k, bad, i, n;
        logic b, ea, eb;
        start = 1'b1;
        tick();
        busy_cnt = 0; done_cnt = 0; done_k = -1; k = -1; bad = 0;
        while (busy === 1'b1 && busy_cnt < 2000) begin
            busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (k == -1) start = 1'b0;
            if (k >= 0) begin
                if (k < 32 * p) begin
                    i  = k / p;
                    n  = (i < 8) ? (8 - i) : (i + 1);
                    b  = w[n-1];
                    ea = ((k % p) < (p / 2)) ? b : 1'b0;
                    eb = ((k % p) < (p / 2)) ? ~b : 1'b0;
                    if (bit_idx !== 5'(i)) bad++;
                end else begin
                    ea = 1'b0;
                    eb = 1'b0;
                end
                if (txa !== ea || txb !== eb) bad++;
            end
            if (k == edge_k) start = 1'b1;
            if (k == edge_k + 2) start = 1'b0;
            if (k == tog_k) send_rate = ~send_rate;
            k++;
            tick();
        end
        chk({tag, "_word"}, word_out, w);
        chk({tag, "_line_errs"}, bad, 0);
        chk({tag, "_busy_len"}, busy_cnt, 1 + 36 * p);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_pos"}, done_k, 36 * p - 1);
        chk({tag, "_done_low_after"}, {31'b0, done}, 0);
    endtask

    initial begin
        int idle_busy;
        int found;
        int done_seen;

        rst = 1'b1; start = 1'b0; send_rate = 1'b0;
        dat0 = 4'h0; dat1 = 4'h0; dat2 = 4'h0; dat3 = 4'h0; dat4 = 4'h0; dat5 = 4'h0;
        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_txa", {31'b0, txa}, 0);
        chk("rst_txb", {31'b0, txb}, 0);
        chk("rst_word", word_out, 0);
        chk("rst_bit_idx", {27'b0, bit_idx}, 0);
        rst = 1'b0;
        tick();

        // Scenario 1: label A5, high speed.
        dat0 = 4'h5; dat1 = 4'hA;
        run_word(32'h8000_00A5, 4, "s1", -100, -100);
        tick();

        // Scenario 2: same word at low speed.
        send_rate = 1'b1;
        run_word(32'h8000_00A5, 8, "s2", -100, -100);
        send_rate = 1'b0;
        tick();

        // Scenario 3: data field with nine ones, parity bit clear.
        dat0 = 4'h0; dat1 = 4'h0; dat2 = 4'hF; dat3 = 4'hF; dat4 = 4'h0; dat5 = 4'h1;
        run_word(32'h0043_FC00, 4, "s3", -100, -100);
        tick();

        // Scenario 4: start edge at bit 10 and rate toggle mid-word are ignored.
        dat0 = 4'h5; dat1 = 4'hA; dat2 = 4'h0; dat3 = 4'h0; dat4 = 4'h0; dat5 = 4'h0;
        run_word(32'h8000_00A5, 4, "s4", 40, 20);
        send_rate = 1'b0;
        idle_busy = 0;
        for (int c = 0; c < 6; c++) begin
            if (busy === 1'b1) idle_busy++;
            tick();
        end
        chk("s4_no_restart", idle_busy, 0);

        // Scenario 5: start held high across reset release does not trigger.
        start = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle_busy = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (busy === 1'b1) idle_busy++;
        end
        chk("s5_held_no_tx", idle_busy, 0);
        start = 1'b0;
        tick();
        run_word(32'h8000_00A5, 4, "s5", -100, -100);
        tick();

        // Scenario 6: reset in the middle of bit 20.
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        done_seen = 0;
        for (int c = 0; c < 400; c++) begin
            if (done === 1'b1) done_seen++;
            if (c > 0 && busy === 1'b1 && bit_idx === 5'd20) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("s6_reached_bit20", found, 1);
        rst = 1'b1;
        tick();
        if (done === 1'b1) done_seen++;
        chk("s6_txa", {31'b0, txa}, 0);
        chk("s6_txb", {31'b0, txb}, 0);
        chk("s6_busy", {31'b0, busy}, 0);
        chk("s6_word", word_out, 0);
        chk("s6_no_done", done_seen, 0);
        rst = 1'b0;
        tick();
        chk("s6_idle_after", {31'b0, busy}, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/a429_tx_ctrl.md
Name: a429_tx_ctrl

Overview:
- Transmit sequencer for the ARINC429 link between the two FPGAs.
- On a start request it snapshots the six keypad digits and the selected transmit rate.
- It assembles a 32-bit ARINC429 word with odd parity, then drives the bipolar return-to-zero line pair bit by bit.
- After the word it enforces the inter-word null gap, then pulses done.
- Sits between the keypad/digit-entry logic and the line driver pins.

Parameters:
BIT_DIV_HI, 500, clk cycles per bit at high speed (100 kbps @ 50 MHz); must be even and >= 4
BIT_DIV_LO, 4000, clk cycles per bit at low speed (12.5 kbps @ 50 MHz); must be even and >= 4
GAP_BITS, 4, null bit-times inserted after each word

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  send request (level, registered by upstream); rising edge triggers
send_rate  in  1  0 = high speed (BIT_DIV_HI), 1 = low speed (BIT_DIV_LO)
dat0..dat5  in  4 each  digit values; dat0 = label low nibble, dat1 = label high nibble, dat2..dat5 = data nibbles
busy  out  1  high from LOAD through end of GAP
done  out  1  one-cycle pulse when GAP completes
txa  out  1  line A: high during first half of a '1' bit
txb  out  1  line B: high during first half of a '0' bit
word_out  out  32  last assembled word (bit0 = ARINC bit 1)
bit_idx  out  5  index of the bit currently on the line (0..31, transmission order)

Behaviour:
- Reset:
  - state = IDLE; txa = txb = busy = done = 0; word_out = 0; bit_idx = 0.
  - Counters are cleared.
  - Start-edge register is set to 1, so a start already held high through reset does not trigger.
- Start detect: trigger when start = 1 and start_d = 0, and only in IDLE. Edges in any other state are ignored; they are not queued.
- States:
  - IDLE -> LOAD on trigger.
  - LOAD (1 cycle) -> SEND.
  - SEND -> GAP after bit 31's full period.
  - GAP -> IDLE after GAP_BITS periods, with done = 1 in the final GAP cycle.
- LOAD actions:
  - Latch send_rate into rate_r, which fixes the period P for the entire word; later changes to send_rate do not affect it.
  - Assemble word_out (ARINC bit n maps to word_out[n-1]):
    - bits 1-8: label {dat1, dat0}.
    - bits 9-10 (SDI) = 0.
    - bits 11-26 = {dat5, dat4, dat3, dat2}, with dat2[0] at bit 11.
    - bits 27-29 = 0.
    - bits 30-31 (SSM) = 0.
    - bit 32 = parity, chosen so the total count of ones in the word is odd.
- Transmission order:
  - Label first, MSB first: ARINC bits 8,7,…,1.
  - Then ARINC bits 9,10,…,32 in ascending order.
  - bit_idx counts 0..31 in this order.
- Bit timing:
  - Each bit lasts P cycles.
  - First P/2 cycles: txa = bit, txb = ~bit.
  - Last P/2 cycles: txa = txb = 0 (null).
  - The first bit's first half begins in the cycle after LOAD.
  - txa and txb are never 1 simultaneously.
- GAP: txa = txb = 0 for GAP_BITS×P cycles; busy stays 1.
- Total busy duration: 1 + (32 + GAP_BITS)×P cycles.
- done and a new trigger in the same cycle: the new trigger is ignored, because the FSM is not yet in IDLE. A trigger is accepted from the following cycle.
- rst asserted mid-word: on the next edge the FSM returns to IDLE with the lines nulled and no done pulse. word_out is cleared.
- Counter widths must hold BIT_DIV_LO - 1 without overflow.

Test Plan:
- Use BIT_DIV_HI = 4, BIT_DIV_LO = 8, GAP_BITS = 4.
- Scenario 1: dat0 = 5, dat1 = A, dat2..dat5 = 0, send_rate = 0, pulse start -> word_out = 32'h8000_00A5. The line sequence for the first 8 bits is 1,0,1,0,0,1,0,1. Bit 32 is sent as '1'. busy lasts 1 + 36×4 = 145 cycles, then a single-cycle done.
- Scenario 2: same digits, send_rate = 1 -> each bit has 4 driven cycles plus 4 null cycles; busy lasts 289 cycles.
- Scenario 3: dat2 = F, dat3 = F, dat4 = 0, dat5 = 1, label 00 -> bits 11-18 and bit 23 are 1, giving 9 ones, so parity = 0. word_out = 32'h0043_FC00.
- Scenario 4: second start rising edge at bit_idx = 10; toggle send_rate mid-word -> no restart, no timing change, and exactly one done.
- Scenario 5: hold start high across reset release -> no transmission. Then drop start and raise it -> a transmission occurs.
- Scenario 6: assert rst at bit_idx = 20 -> next cycle txa = txb = busy = 0, no done, and word_out = 0.
- In all scenarios, a checker asserts that txa & txb is never 1.
